// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared types, button indices and ms-to-cycles helper
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_SUBIR  = 0;
    localparam int BTN_DESCER = 1;
    localparam int BTN_ENTRAR = 2;
    localparam int BTN_VOLTAR = 3;

    // Whole-millisecond clock counts; CLK_HZ is assumed to be a multiple of 1 kHz.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button pin / conditioned output bundle with master/slave views
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 4
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;

    // master: board side driving the raw pins and observing the results
    modport master (
        output btn_n,
        input  level,
        input  press,
        input  rel
    );

    // slave: the conditioner
    modport slave (
        input  btn_n,
        output level,
        output press,
        output rel
    );
endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchronizer, debounce counter/FSM, optional auto-repeat (BTN_AUTOREPEAT_EN)
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 8,
    parameter int unsigned SYNC_STAGES = 2
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned RPT_DELAY   = 40,
    parameter int unsigned RPT_RATE    = 10
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o,
    output logic rel_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    btn_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   s;

    // Shift the raw pin through the synchronizer; s is the pressed request.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_n_i};
    assign s      = ~sync_q[SYNC_STAGES-1];

    // Debounce FSM: a level change is accepted only after DB_CYCLES consecutive
    // samples agree; any reversal drops back and restarts the count.
    // With DB_CYCLES == 1 the first stable sample is already enough, so the wait
    // states are skipped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    if (DB_CYCLES == 1) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (DB_CYCLES == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(RPT_DELAY + 1);
    localparam logic [RW-1:0] RPT_ONE    = RW'(1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(RPT_DELAY);
    // Reloading below the fire point makes the next repeat land RPT_RATE cycles later.
    localparam logic [RW-1:0] RPT_RELOAD = RW'(RPT_DELAY - RPT_RATE + 1);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_fire;

    // Repeat timer: restarts on acceptance, runs while PRESSED, freezes in RELEASE_WAIT.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (state_q != PRESSED && state_q != RELEASE_WAIT && state_d == PRESSED) begin
            rpt_cnt_d = '0;
        end else if (state_q == PRESSED) begin
            if (rpt_cnt_q == RPT_LAST) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = RPT_RELOAD;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_ONE;
            end
        end
    end
`endif

    // Outputs are registered from the state one cycle after the transition;
    // pulses are the edges of the debounced level, so press and release can never coincide.
    always_comb begin
        level_d = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        rel_d   = level_q & ~level_d;
`ifdef BTN_AUTOREPEAT_EN
        press_d = (level_d & ~level_q) | rpt_fire;
`else
        press_d = level_d & ~level_q;
`endif
    end

    // State, counter, synchronizer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    assign level_o = level_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced levels and press/release pulses for the Nios button PIOs (option BTN_AUTOREPEAT_EN)
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned DEBOUNCE_MS  = 20,
    parameter int unsigned DB_CYCLES    = ms_to_cycles(CLK_HZ, DEBOUNCE_MS),
    parameter int unsigned SYNC_STAGES  = 2
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY_MS     = 500,
    parameter int unsigned REPEAT_RATE_MS      = 100,
    parameter int unsigned REPEAT_DELAY_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS),
    parameter int unsigned REPEAT_RATE_CYCLES  = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS)
`endif
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] btn_n_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o
);

    // One independent conditioning channel per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .RPT_DELAY   (REPEAT_DELAY_CYCLES),
            .RPT_RATE    (REPEAT_RATE_CYCLES)
`endif
        ) u_chan (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .btn_n_i (btn_n_i[i]),
            .level_o (btn_level_o[i]),
            .press_o (btn_press_o[i]),
            .rel_o   (btn_release_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
`timescale 1ns/1ps
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   press_tot [4];
    int   rel_tot   [4];
    int   both_tot  = 0;
    int   p_base    [4];
    int   r_base    [4];

    always #5 clk = ~clk;

    button_conditioner_if #(.N_BTN(4)) bif ();

    button_conditioner #(
        .N_BTN       (4),
        .DB_CYCLES   (8),
        .SYNC_STAGES (2)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY_CYCLES (40),
        .REPEAT_RATE_CYCLES  (10)
`endif
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .btn_n_i       (bif.btn_n),
        .btn_level_o   (bif.level),
        .btn_press_o   (bif.press),
        .btn_release_o (bif.rel)
    );

    initial begin
        for (int i = 0; i < 4; i++) begin
            press_tot[i] = 0;
            rel_tot[i]   = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            press_tot[i] += int'(bif.press[i]);
            rel_tot[i]   += int'(bif.rel[i]);
            if (bif.press[i] && bif.rel[i]) both_tot++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            p_base[i] = press_tot[i];
            r_base[i] = rel_tot[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bif.btn_n = 4'b0000;
        step(3);
        check("rst_level", 32'(bif.level), 32'h0);
        check("rst_press", 32'(bif.press), 32'h0);
        check("rst_release", 32'(bif.rel), 32'h0);

        // Release reset with all buttons held: accepted 11 cycles later.
        snap();
        rst_n = 1'b1;
        step(10);
        check("hold_lvl_t10", 32'(bif.level), 32'h0);
        step(1);
        check("hold_lvl_t11", 32'(bif.level), 32'hF);
        check("hold_press_t11", 32'(bif.press), 32'hF);
        step(1);
        check("hold_press_t12", 32'(bif.press), 32'h0);
        check("hold_pulse_count", 32'((press_tot[0] - p_base[0]) + (press_tot[1] - p_base[1])
              + (press_tot[2] - p_base[2]) + (press_tot[3] - p_base[3])), 32'd4);

        bif.btn_n = 4'hF;
        step(10);
        check("allrel_t10", 32'(bif.rel), 32'h0);
        step(1);
        check("allrel_t11", 32'(bif.rel), 32'hF);
        check("allrel_lvl", 32'(bif.level), 32'h0);
        step(1);
        check("allrel_t12", 32'(bif.rel), 32'h0);
        step(5);

        // Clean press and release on entrar.
        bif.btn_n = 4'b1011;
        step(10);
        check("b2_lvl_t10", 32'(bif.level), 32'h0);
        step(1);
        check("b2_lvl_t11", 32'(bif.level), 32'h4);
        check("b2_press_t11", 32'(bif.press), 32'h4);
        step(1);
        check("b2_press_t12", 32'(bif.press), 32'h0);
        step(5);
        bif.btn_n = 4'hF;
        step(10);
        check("b2_rel_t10", 32'(bif.rel), 32'h0);
        step(1);
        check("b2_rel_t11", 32'(bif.rel), 32'h4);
        check("b2_rel_lvl", 32'(bif.level), 32'h0);
        step(1);
        check("b2_rel_t12", 32'(bif.rel), 32'h0);
        step(5);

        // Bounce on subir: reversal every 3 cycles, then a clean low.
        snap();
        for (int k = 0; k < 10; k++) begin
            bif.btn_n[0] = k[0];
            step(3);
            check("bounce_lvl", 32'(bif.level[0]), 32'h0);
        end
        bif.btn_n[0] = 1'b0;
        step(10);
        check("bounce_lvl_t10", 32'(bif.level[0]), 32'h0);
        step(1);
        check("bounce_lvl_t11", 32'(bif.level[0]), 32'h1);
        check("bounce_press_t11", 32'(bif.press), 32'h1);
        step(3);
        check("bounce_press_count", 32'(press_tot[0] - p_base[0]), 32'd1);
        bif.btn_n[0] = 1'b1;
        step(20);

        // Glitch on descer: 7 cycles is one short of acceptance.
        snap();
        bif.btn_n[1] = 1'b0;
        step(7);
        bif.btn_n[1] = 1'b1;
        step(15);
        check("glitch_lvl", 32'(bif.level), 32'h0);
        check("glitch_press", 32'(press_tot[1] - p_base[1]), 32'd0);
        check("glitch_rel", 32'(rel_tot[1] - r_base[1]), 32'd0);

        // Simultaneous subir + voltar.
        bif.btn_n = 4'b0110;
        step(11);
        check("simul_press", 32'(bif.press), 32'h9);
        check("simul_lvl", 32'(bif.level), 32'h9);
        step(1);
        check("simul_press_t12", 32'(bif.press), 32'h0);

        // Reset mid-debounce of entrar (counter at 5) while subir/voltar are held.
        bif.btn_n = 4'b0010;
        step(7);
        snap();
        rst_n = 1'b0;
        #1;
        check("midrst_lvl", 32'(bif.level), 32'h0);
        check("midrst_press", 32'(bif.press), 32'h0);
        step(2);
        bif.btn_n = 4'hF;
        rst_n     = 1'b1;
        step(20);
        check("postrst_lvl", 32'(bif.level), 32'h0);
        check("postrst_pulses", 32'((press_tot[0] - p_base[0]) + (press_tot[2] - p_base[2])
              + (press_tot[3] - p_base[3]) + (rel_tot[0] - r_base[0])
              + (rel_tot[2] - r_base[2]) + (rel_tot[3] - r_base[3])), 32'd0);

        // Long hold on voltar: repeats only with the auto-repeat option.
        snap();
        bif.btn_n = 4'b0111;
        step(11);
        check("long_press_acc", 32'(bif.press), 32'h8);
`ifdef BTN_AUTOREPEAT_EN
        step(40);
        check("rpt_t40", 32'(bif.press), 32'h8);
        step(1);
        check("rpt_t41", 32'(bif.press), 32'h0);
        step(9);
        check("rpt_t50", 32'(bif.press), 32'h8);
        step(10);
        check("rpt_t60", 32'(bif.press), 32'h8);
        step(35);
        check("rpt_lvl", 32'(bif.level), 32'h8);
        check("rpt_count", 32'(press_tot[3] - p_base[3]), 32'd7);
`else
        step(95);
        check("long_lvl", 32'(bif.level), 32'h8);
        check("long_count", 32'(press_tot[3] - p_base[3]), 32'd1);
`endif
        bif.btn_n = 4'hF;
        step(11);
        check("long_rel", 32'(bif.rel), 32'h8);
        step(2);
        check("no_overlap", 32'(both_tot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
